param_updown_counter: RTL

Parametrised up/down counter, the successor to the team's fixed 4-bit free-running counter. Adds enable, a programmable modulus, a built-in prescaler, synchronous parallel load, run-time wrap/saturate mode, a terminal-count pulse and a sticky wrap flag. It is the general-purpose timing and event counter for the digital-systems designs: decade counters, clock dividers and timeouts.

---
 rtl/counter_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 42 ++++
 rtl/param_updown_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings and helpers for the counter/timing blocks.
//   DIR_UP / DIR_DOWN    : values of the direction input
//   MODE_WRAP / MODE_SAT : values of the saturate-mode input
//   clog2()              : bit width needed to hold 0..v-1, for sizing counters
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Returns ceil(log2(v)), with a floor of 1 so callers always get a legal width.
  function automatic int clog2(input longint unsigned v);
    int              r;
    longint unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled clocks into one tick every PRESCALE of them.
//   iClk  : clock, rising edge
//   iRst  : synchronous active-high reset, phase -> 0
//   iEn   : advance enable; phase holds while low
//   iClr  : synchronous phase clear (e.g. on a parallel load)
//   oTick : iEn && phase == PRESCALE-1 (combinational, for the owning block)
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  output logic oTick
);

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("tick_prescaler: PRESCALE must be >= 1 (got %0d)", PRESCALE);
    end else if (PRESCALE == 1) begin : g_bypass
      // Every enabled clock is a tick; no state is needed.
      logic unused_ins;
      assign unused_ins = ^{iClk, iRst, iClr};
      assign oTick      = iEn;
    end else begin : g_div
      localparam int            PW   = clog2(longint'(PRESCALE));
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge iClk) begin
        if (iRst || iClr)  phase <= '0;
        else if (iEn)      phase <= (phase == LAST) ? '0 : phase + 1'b1;
      end

      assign oTick = iEn && (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: general-purpose up/down event counter over 0..MAX_VAL.
//   iClk      : clock, rising edge
//   iRst      : synchronous active-high reset (overrides everything)
//   iEn       : count enable, also gates the prescaler
//   iDir      : 1 = up, 0 = down
//   iSat      : 1 = saturate at the range ends, 0 = wrap around
//   iLoad     : synchronous parallel load (beats counting, ignores iEn)
//   iLoadVal  : load value, clamped to MAX_VAL
//   iClrWrap  : clears oWrap (a same-cycle wrap event wins)
//   oCount    : registered count
//   oTc       : registered one-cycle pulse after a tick taken at the terminal value
//   oWrap     : registered sticky wrap flag
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = 9,
  parameter int              PRESCALE = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iDir,
  input  logic             iSat,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  input  logic             iClrWrap,
  output logic [WIDTH-1:0] oCount,
  output logic             oTc,
  output logic             oWrap
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("param_updown_counter: WIDTH must be 1..32 (got %0d)", WIDTH);
    end
    if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("param_updown_counter: MAX_VAL %0d outside 1..2^WIDTH-1", MAX_VAL);
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("param_updown_counter: PRESCALE must be >= 1 (got %0d)", PRESCALE);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic             tick;
  logic             step;
  logic             at_term;
  logic             wrap_evt;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             wrap_q;

  // Load clears the phase so a count always begins a full PRESCALE period
  // after the load edge.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .iClk  (iClk),
    .iRst  (iRst),
    .iEn   (iEn),
    .iClr  (iLoad),
    .oTick (tick)
  );

  // A prescaler tick landing on a load edge is swallowed: load has priority.
  assign step     = tick && !iLoad;
  assign at_term  = (iDir == DIR_UP) ? (count_q == MAX_C) : (count_q == '0);
  assign wrap_evt = step && at_term && (iSat == MODE_WRAP);

  always_comb begin
    count_d = count_q;
    if (iLoad) begin
      count_d = (iLoadVal > MAX_C) ? MAX_C : iLoadVal;
    end else if (step) begin
      if (at_term) begin
        if (iSat == MODE_WRAP) count_d = (iDir == DIR_UP) ? '0 : MAX_C;
      end else begin
        count_d = (iDir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      // tc fires on every terminal tick, including repeated saturated ones.
      tc_q    <= step && at_term;
      // Set beats clear; load leaves the flag alone.
      wrap_q  <= wrap_evt || (wrap_q && !iClrWrap);
    end
  end

  assign oCount = count_q;
  assign oTc    = tc_q;
  assign oWrap  = wrap_q;

endmodule
